// File: rtl/taillight_sequencer.sv
// Sequential turn-signal taillight controller: a prescaler sets the step rate and
// an FSM walks the left or right three-lamp pattern once per step.
module taillight_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  output logic [2:0] state,
  output logic       tick,
  output logic       busy
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    R1   = 3'b001,
    R2   = 3'b010,
    R3   = 3'b011,
    L1   = 3'b100,
    L2   = 3'b101,
    L3   = 3'b110
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic          step;

  // With TICK_DIV=1 the single counter bit stays 0, so every edge is a step edge.
  assign step = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= step ? '0 : cnt + CW'(1);
      tick <= step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (step) begin
          if (left && !right)      state_d = L1;
          else if (right && !left) state_d = R1;
        end
      end
      L1: if (step) state_d = L2;
      L2: if (step) state_d = L3;
      L3: if (step) state_d = IDLE;
      R1: if (step) state_d = R2;
      R2: if (step) state_d = R3;
      R3: if (step) state_d = IDLE;
      // The spare code 111 recovers immediately, without waiting for a step.
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed bench for taillight_sequencer: a TICK_DIV=4 instance for the main
// sequences and a TICK_DIV=1 instance for the every-cycle stepping mode.
module tb_taillight_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset, left, right;
  logic [2:0] state;
  logic       tick, busy;
  logic       reset1, left1, right1;
  logic [2:0] state1;
  logic       tick1, busy1;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  logic [2:0] cur_exp = 3'b000;
  logic [2:0] exp_q[$];

  taillight_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .state(state), .tick(tick), .busy(busy)
  );

  taillight_sequencer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset1), .left(left1), .right(right1),
    .state(state1), .tick(tick1), .busy(busy1)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks; all sampling happens on the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [2:0] v);
    exp_q.push_back(v);
  endtask

  // Advance to the next step edge of the TICK_DIV=4 instance, checking that the
  // state holds in between, then pop the expected post-step state.
  task automatic to_step(input string tag);
    logic [2:0] e;
    do begin
      cyc(1);
      if (ncyc % TD != 0) chk({tag, "_hold"}, state, cur_exp);
    end while (ncyc % TD != 0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_queue observed=empty expected=entry", tag);
      e = cur_exp;
    end else begin
      e = exp_q.pop_front();
    end
    chk(tag, state, e);
    chk({tag, "_tick"}, {2'b00, tick}, 3'b001);
    chk({tag, "_busy"}, {2'b00, busy}, {2'b00, (e != 3'b000)});
    cur_exp = e;
  endtask

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0;
    reset1 = 1'b1; left1 = 1'b0; right1 = 1'b0;

    // Reset held for two edges
    cyc(2);
    chk("rst_state", state, 3'b000);
    chk("rst_busy", {2'b00, busy}, 3'b000);
    chk("rst_tick", {2'b00, tick}, 3'b000);
    chk("rst1_tick", {2'b00, tick1}, 3'b000);
    reset = 1'b0;
    ncyc  = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      chk($sformatf("post_rst_tick%0d", i), {2'b00, tick}, (i == 4) ? 3'b001 : 3'b000);
      chk($sformatf("post_rst_state%0d", i), state, 3'b000);
    end

    // Left held: L1, L2, L3, IDLE, then restart at L1
    left = 1'b1;
    push(3'b100); push(3'b101); push(3'b110); push(3'b000); push(3'b100);
    for (int i = 0; i < 5; i++) to_step($sformatf("left%0d", i));
    left = 1'b0;
    push(3'b101); push(3'b110); push(3'b000); push(3'b000);
    for (int i = 0; i < 4; i++) to_step($sformatf("left_run%0d", i));

    // Right asserted only across a single step edge
    while (ncyc % TD != TD - 1) cyc(1);
    right = 1'b1;
    push(3'b001); push(3'b010); push(3'b011); push(3'b000); push(3'b000);
    to_step("right0");
    right = 1'b0;
    for (int i = 1; i < 5; i++) to_step($sformatf("right%0d", i));

    // Both requests: no sequence starts
    left = 1'b1; right = 1'b1;
    push(3'b000); push(3'b000); push(3'b000);
    for (int i = 0; i < 3; i++) to_step($sformatf("both%0d", i));
    left = 1'b0; right = 1'b0;

    // Two-cycle left glitch between step edges is ignored
    cyc(1);
    left = 1'b1;
    cyc(2);
    chk("glitch_mid", state, 3'b000);
    left = 1'b0;
    push(3'b000);
    to_step("glitch");

    // Abort in L2, then restart counting from reset release
    left = 1'b1;
    push(3'b100); push(3'b101);
    to_step("abort_l1");
    to_step("abort_l2");
    reset = 1'b1;
    cyc(1);
    chk("abort_state", state, 3'b000);
    chk("abort_busy", {2'b00, busy}, 3'b000);
    chk("abort_tick", {2'b00, tick}, 3'b000);
    reset   = 1'b0;
    ncyc    = 0;
    cur_exp = 3'b000;
    push(3'b100);
    to_step("abort_restart");
    left = 1'b0;
    push(3'b101); push(3'b110); push(3'b000);
    for (int i = 0; i < 3; i++) to_step($sformatf("abort_run%0d", i));

    // TICK_DIV=1: a step on every edge
    reset1 = 1'b0;
    right1 = 1'b1;
    push(3'b001); push(3'b010); push(3'b011); push(3'b000); push(3'b001);
    for (int i = 0; i < 5; i++) begin
      logic [2:0] e;
      cyc(1);
      e = exp_q.pop_front();
      chk($sformatf("td1_state%0d", i), state1, e);
      chk($sformatf("td1_tick%0d", i), {2'b00, tick1}, 3'b001);
      chk($sformatf("td1_busy%0d", i), {2'b00, busy1}, {2'b00, (e != 3'b000)});
    end
    right1 = 1'b0;

    chk("queue_drained", 3'(exp_q.size()), 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/taillight_sequencer.md
TAILLIGHT_SEQUENCER -- requirements
Module: taillight_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, meaning clock cycles per sequence step; legal range 1..2^24.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port left  input  1  left turn request, level-sensitive, synchronous to clk.
REQ-005 Port right  input  1  right turn request, level-sensitive, synchronous to clk.
REQ-006 Port state  output  3  registered light-sequence code for the taillight decoder.
REQ-007 Port tick  output  1  registered one-cycle step strobe.
REQ-008 Port busy  output  1  high whenever state is not IDLE; combinational from the state register.

Function
REQ-009 State codes SHALL be fixed:
- IDLE=000, R1=001, R2=010, R3=011, L1=100, L2=101, L3=110.
- Code 111 SHALL never be produced.
REQ-010 Prescaler counter cnt SHALL be ceil(log2(TICK_DIV)) bits wide, minimum 1 bit.
- Increments every cycle.
- Wraps to 0 after reaching TICK_DIV-1.
REQ-011 tick SHALL be 1 in exactly the cycle after cnt equals TICK_DIV-1, else 0.
- TICK_DIV=1: tick held high every cycle after reset.
REQ-012 State SHALL update only on a rising edge where cnt==TICK_DIV-1 (the step edge); it holds at all other edges.
REQ-013 IDLE transitions at a step edge, using left/right sampled at that edge:
- left=1, right=0 -> L1.
- right=1, left=0 -> R1.
- both 0 or both 1 -> IDLE.
REQ-014 Once started, a sequence SHALL run to completion at successive step edges, regardless of left/right:
- L1->L2->L3->IDLE.
- R1->R2->R3->IDLE.
REQ-015 Requests still asserted on return to IDLE SHALL restart the sequence at the next step edge after IDLE is entered (IDLE lasts one full step period minimum).
REQ-016 Requests asserted and removed entirely between step edges SHALL be ignored; no latching.
REQ-017 Any unreachable state-register value (111) SHALL go to IDLE at the next clock edge, independent of cnt.
REQ-018 Latency: state reflects a step-edge decision one cycle after that edge; no combinational path from left/right to state.

Reset
REQ-019 While reset=1 at a rising edge, the next values SHALL be:
- state=000, cnt=0, tick=0, busy=0.
- Reset overrides the step-edge condition in the same cycle.
REQ-020 Reset asserted mid-sequence (e.g. in L2) SHALL abort it to IDLE with no further steps.
- Counting restarts from cnt=0 on the first edge with reset=0.
REQ-021 After reset deasserts, the first step edge SHALL be the TICK_DIV-th rising edge with reset=0.

Verification (TICK_DIV=4 unless stated)
REQ-022 Reset: hold reset 2 cycles, then release -> state=000, busy=0, tick=0; tick first high after the 4th edge post-release.
REQ-023 Left sequence: left=1 held -> state 100, 101, 110, 000, 100 at successive step edges, 4 cycles apart; busy=1 except in 000.
REQ-024 Right pulse: right=1 for exactly the cycle containing one step edge -> full sequence 001, 010, 011, 000, then stays 000.
REQ-025 Conflicts and glitches:
- left=right=1 across 3 step edges -> state stays 000.
- left pulse of 2 cycles between step edges -> no change.
REQ-026 Abort and mode:
- reset at state 101 -> 000 next edge; left held -> 100 at the 4th edge after release.
- With TICK_DIV=1, right held -> 001, 010, 011, 000 on consecutive cycles.
